keymgr_input_chk_seq: RTL and testbench

//  Word-serial sequencer for key manager input validity checks. On start, scans creator seed,

---
 rtl/keymgr_input_chk_seq_pkg.sv | 80 ++++++++
 rtl/keymgr_input_chk_seq_if.sv | 41 ++++
 rtl/keymgr_input_chk_seq_chk_acc.sv | 46 ++++
 rtl/keymgr_input_chk_seq.sv | 199 +++++++++++++++++++
 tb/tb_keymgr_input_chk_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keymgr_input_chk_seq_pkg.sv
// -----------------------------------------------------------------------------
// keymgr_input_chk_seq_pkg
// Shared types and sizing for the word-serial key manager input checker.
//   - Field/word geometry: KeyWidth, DevIdWidth, HealthStateWidth, WordWidth
//   - keymgr_stage_e / hw_key_req_t: the raw input types seen by the checker
//   - chk_field_e: scan order of the fields (creator first, share1 last)
//   - chk_state_e: sequencer states
//   - chk_last_word(): index of the last word of a given field
// -----------------------------------------------------------------------------
package keymgr_input_chk_seq_pkg;

  localparam int KeyWidth         = 256;
  localparam int DevIdWidth       = 256;
  localparam int HealthStateWidth = 128;
  localparam int WordWidth        = 32;
  localparam int ChkWordWidth     = WordWidth;
  localparam int NumChkFields     = 6;
  localparam int NumFields        = NumChkFields;

  localparam int StageWidth = 2;
  localparam int NumStages  = 2 ** StageWidth;

  // Words per field
  localparam int KeyWords    = KeyWidth / WordWidth;
  localparam int DevIdWords  = DevIdWidth / WordWidth;
  localparam int HealthWords = HealthStateWidth / WordWidth;
  localparam int CreatorWords = KeyWords;
  localparam int OwnerWords   = KeyWords;
  localparam int Share0Words  = KeyWords;
  localparam int Share1Words  = KeyWords;

  localparam int MaxWordsKd = (KeyWords > DevIdWords) ? KeyWords : DevIdWords;
  localparam int MaxWords   = (MaxWordsKd > HealthWords) ? MaxWordsKd : HealthWords;

  localparam int WordIdxW   = $clog2(MaxWords);
  localparam int HealthIdxW = $clog2(HealthWords);
  localparam int FieldIdxW  = $clog2(NumChkFields);

  typedef enum logic [StageWidth-1:0] {
    StageCreatorRootKey,
    StageOwnerIntKey,
    StageOwnerKey,
    StageDisable
  } keymgr_stage_e;

  typedef struct packed {
    logic                     valid;
    logic [1:0][KeyWidth-1:0] key;
  } hw_key_req_t;

  typedef enum logic [FieldIdxW-1:0] {
    ChkCreator,
    ChkOwner,
    ChkDevId,
    ChkHealth,
    ChkShare0,
    ChkShare1
  } chk_field_e;

  typedef enum logic [1:0] {
    ChkIdle,
    ChkScan,
    ChkDone
  } chk_state_e;

  function automatic logic [WordIdxW-1:0] chk_last_word(input logic [FieldIdxW-1:0] field);
    logic [WordIdxW-1:0] last;
    case (field)
      ChkCreator: last = WordIdxW'(CreatorWords - 1);
      ChkOwner:   last = WordIdxW'(OwnerWords - 1);
      ChkDevId:   last = WordIdxW'(DevIdWords - 1);
      ChkHealth:  last = WordIdxW'(HealthWords - 1);
      ChkShare0:  last = WordIdxW'(Share0Words - 1);
      ChkShare1:  last = WordIdxW'(Share1Words - 1);
      default:    last = '0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/keymgr_input_chk_seq_if.sv
// -----------------------------------------------------------------------------
// keymgr_input_chk_seq_if
// Bundles the start/done handshake, the raw input buses and the check results.
//   master: op FSM / bench side (drives start and inputs, reads results)
//   slave : the checker itself
// Inputs : start_i, stage_sel_i, max_key_versions_i, key_version_i,
//          creator_seed_i, owner_seed_i, devid_i, health_state_i, key_i
// Outputs: busy_o, done_o, field_vld_o, key_version_vld_o, all_vld_o
// -----------------------------------------------------------------------------
interface keymgr_input_chk_seq_if;
  import keymgr_input_chk_seq_pkg::*;

  logic                            start_i;
  keymgr_stage_e                   stage_sel_i;
  logic [NumStages-1:0][31:0]      max_key_versions_i;
  logic [31:0]                     key_version_i;
  logic [KeyWidth-1:0]             creator_seed_i;
  logic [KeyWidth-1:0]             owner_seed_i;
  logic [DevIdWidth-1:0]           devid_i;
  logic [HealthStateWidth-1:0]     health_state_i;
  hw_key_req_t                     key_i;

  logic                            busy_o;
  logic                            done_o;
  logic [NumChkFields-1:0]         field_vld_o;
  logic                            key_version_vld_o;
  logic                            all_vld_o;

  modport master (
    output start_i, stage_sel_i, max_key_versions_i, key_version_i,
           creator_seed_i, owner_seed_i, devid_i, health_state_i, key_i,
    input  busy_o, done_o, field_vld_o, key_version_vld_o, all_vld_o
  );

  modport slave (
    input  start_i, stage_sel_i, max_key_versions_i, key_version_i,
           creator_seed_i, owner_seed_i, devid_i, health_state_i, key_i,
    output busy_o, done_o, field_vld_o, key_version_vld_o, all_vld_o
  );

endinterface

// File: rtl/keymgr_input_chk_seq_chk_acc.sv
// -----------------------------------------------------------------------------
// keymgr_chk_acc
// Running all-0 / all-1 detector for one field, fed one word per cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart accumulation (new scan accepted)
//   en_i          : word_i is a valid word of the current field
//   last_i        : word_i is the last word of the field; accumulators restart
//   word_i        : current word
//   any_one_o     : some bit seen so far (including word_i) is 1
//   all_one_o     : every bit seen so far (including word_i) is 1
// Outputs include the current word so the field verdict is available in the
// same cycle as its last word.
// -----------------------------------------------------------------------------
module keymgr_chk_acc
  import keymgr_input_chk_seq_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    last_i,
  input  logic [ChkWordWidth-1:0] word_i,
  output logic                    any_one_o,
  output logic                    all_one_o
);

  logic any_one_reg;
  logic all_one_reg;

  assign any_one_o = any_one_reg | (|word_i);
  assign all_one_o = all_one_reg & (&word_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_one_reg <= 1'b0;
      all_one_reg <= 1'b1;
    end else if (clr_i || (en_i && last_i)) begin
      any_one_reg <= 1'b0;
      all_one_reg <= 1'b1;
    end else if (en_i) begin
      any_one_reg <= any_one_o;
      all_one_reg <= all_one_o;
    end
  end

endmodule

// File: rtl/keymgr_input_chk_seq.sv
// -----------------------------------------------------------------------------
// keymgr_input_chk_seq
// Word-serial validity checker for the key manager inputs. After start_i is
// accepted in IDLE, creator seed, owner seed, device ID, health state, key
// share 0 and key share 1 are scanned WordWidth bits per cycle (LSW first)
// through one shared all-0/all-1 accumulator. The key version is compared
// against the selected stage's maximum in the accept cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : start_i/inputs in; busy_o, done_o, field_vld_o,
//                   key_version_vld_o, all_vld_o out (all registered)
// Default latency: 44 scan cycles, done_o pulses in the following DONE cycle.
// Optional feature macro: KEYMGR_INPUT_CHK_EARLY_ABORT_EN -- stop scanning one
// cycle after the first field completes invalid; later field_vld bits stay 0.
// -----------------------------------------------------------------------------
module keymgr_input_chk_seq
  import keymgr_input_chk_seq_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  keymgr_input_chk_seq_if.slave  bus
);

`ifdef KEYMGR_INPUT_CHK_EARLY_ABORT_EN
  localparam bit EarlyAbortEn = 1'b1;
`else
  localparam bit EarlyAbortEn = 1'b0;
`endif

  // Elaboration-time geometry checks
  if ((KeyWidth % WordWidth) != 0) begin : g_key_width_chk
    $error("KeyWidth must be a multiple of WordWidth");
  end
  if ((DevIdWidth % WordWidth) != 0) begin : g_devid_width_chk
    $error("DevIdWidth must be a multiple of WordWidth");
  end
  if ((HealthStateWidth % WordWidth) != 0) begin : g_health_width_chk
    $error("HealthStateWidth must be a multiple of WordWidth");
  end

  chk_state_e              state_reg;
  logic [FieldIdxW-1:0]    field_idx_reg;
  logic [WordIdxW-1:0]     word_idx_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    kv_vld_reg;
  logic                    all_vld_reg;
  logic                    abort_reg;
  logic [NumChkFields-1:0] field_vld_reg;

  // Word views of each field
  logic [KeyWords-1:0][WordWidth-1:0]    creator_words;
  logic [KeyWords-1:0][WordWidth-1:0]    owner_words;
  logic [DevIdWords-1:0][WordWidth-1:0]  devid_words;
  logic [HealthWords-1:0][WordWidth-1:0] health_words;
  logic [KeyWords-1:0][WordWidth-1:0]    share0_words;
  logic [KeyWords-1:0][WordWidth-1:0]    share1_words;

  assign creator_words = bus.creator_seed_i;
  assign owner_words   = bus.owner_seed_i;
  assign devid_words   = bus.devid_i;
  assign health_words  = bus.health_state_i;
  assign share0_words  = bus.key_i.key[0];
  assign share1_words  = bus.key_i.key[1];

  // The valid flag of the key request carries no key material.
  logic unused_key_valid;
  assign unused_key_valid = bus.key_i.valid;

  logic [WordWidth-1:0] word;
  always_comb begin
    word = '0;
    case (field_idx_reg)
      ChkCreator: word = creator_words[word_idx_reg];
      ChkOwner:   word = owner_words[word_idx_reg];
      ChkDevId:   word = devid_words[word_idx_reg];
      ChkHealth:  word = health_words[word_idx_reg[HealthIdxW-1:0]];
      ChkShare0:  word = share0_words[word_idx_reg];
      ChkShare1:  word = share1_words[word_idx_reg];
      default:    word = '0;
    endcase
  end

  logic accept;
  logic scan_step;
  logic word_last;
  logic field_last;
  logic kv_ok;
  logic any_next;
  logic all_next;
  logic field_ok;
  logic all_vld_upd;
  logic [NumChkFields-1:0] field_vld_upd;

  assign accept     = (state_reg == ChkIdle) && bus.start_i;
  // The abort cycle itself consumes no word.
  assign scan_step  = (state_reg == ChkScan) && !(EarlyAbortEn && abort_reg);
  assign word_last  = (word_idx_reg == chk_last_word(field_idx_reg));
  assign field_last = (field_idx_reg == FieldIdxW'(NumChkFields - 1));
  assign kv_ok      = (bus.key_version_i <= bus.max_key_versions_i[bus.stage_sel_i]);
  assign field_ok   = any_next & ~all_next;

  keymgr_chk_acc u_chk_acc (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (accept),
    .en_i      (scan_step),
    .last_i    (word_last),
    .word_i    (word),
    .any_one_o (any_next),
    .all_one_o (all_next)
  );

  for (genvar gi = 0; gi < NumChkFields; gi++) begin : g_fld_upd
    assign field_vld_upd[gi] = (field_idx_reg == FieldIdxW'(gi)) ? field_ok : field_vld_reg[gi];
  end

  assign all_vld_upd = (&field_vld_upd) & kv_vld_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ChkIdle;
      field_idx_reg <= '0;
      word_idx_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      kv_vld_reg    <= 1'b0;
      all_vld_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      field_vld_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ChkIdle: begin
          if (bus.start_i) begin
            // The version verdict is captured here, so stage/version
            // need not stay stable during the scan.
            state_reg     <= ChkScan;
            busy_reg      <= 1'b1;
            field_idx_reg <= '0;
            word_idx_reg  <= '0;
            kv_vld_reg    <= kv_ok;
            all_vld_reg   <= 1'b0;
            abort_reg     <= 1'b0;
            field_vld_reg <= '0;
          end
        end
        ChkScan: begin
          if (EarlyAbortEn && abort_reg) begin
            state_reg   <= ChkDone;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            all_vld_reg <= 1'b0;
          end else if (word_last) begin
            field_vld_reg <= field_vld_upd;
            if (field_last) begin
              state_reg   <= ChkDone;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              all_vld_reg <= all_vld_upd;
            end else begin
              field_idx_reg <= field_idx_reg + 1'b1;
              word_idx_reg  <= '0;
              if (EarlyAbortEn && !field_ok) begin
                abort_reg <= 1'b1;
              end
            end
          end else begin
            word_idx_reg <= word_idx_reg + 1'b1;
          end
        end
        ChkDone: begin
          state_reg <= ChkIdle;
        end
        default: begin
          state_reg <= ChkIdle;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o            = busy_reg;
  assign bus.done_o            = done_reg;
  assign bus.field_vld_o       = field_vld_reg;
  assign bus.key_version_vld_o = kv_vld_reg;
  assign bus.all_vld_o         = all_vld_reg;

  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(busy_reg && done_reg));

  a_done_in_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_reg |-> (state_reg == ChkDone));

  a_inputs_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == ChkScan) |-> ($stable(bus.creator_seed_i) && $stable(bus.owner_seed_i) &&
                                $stable(bus.devid_i) && $stable(bus.health_state_i) &&
                                $stable(bus.key_i.key)));

endmodule

// File: tb/tb_keymgr_input_chk_seq.sv
module tb_keymgr_input_chk_seq;
  import keymgr_input_chk_seq_pkg::*;

`ifdef KEYMGR_INPUT_CHK_EARLY_ABORT_EN
  localparam bit EA = 1'b1;
`else
  localparam bit EA = 1'b0;
`endif

  localparam int NumVecs = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  keymgr_input_chk_seq_if bus();

  keymgr_input_chk_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [255:0]  creator;
    logic [255:0]  owner;
    logic [255:0]  devid;
    logic [127:0]  health;
    logic [255:0]  share0;
    logic [255:0]  share1;
    keymgr_stage_e stage;
    logic [31:0]   max_ver;
    logic [31:0]   other_max;
    logic [31:0]   version;
    logic [5:0]    exp_fv;
    logic          exp_kv;
    logic          exp_all;
    int            exp_lat;
  } vec_t;

  typedef struct {
    int         id;
    logic [5:0] fv;
    logic       kv;
    logic       all;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NumVecs];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic fld_ok(input logic [255:0] val, input int width);
    logic [255:0] m;
    m = '1;
    m = m >> (256 - width);
    return ((val & m) != '0) && ((val & m) != m);
  endfunction

  // Random non-degenerate vector, version equal to max, all valid.
  task automatic new_vec(output vec_t v);
    logic [255:0] tmp;
    v.creator = rnd256();
    v.owner   = rnd256();
    v.devid   = rnd256();
    tmp       = rnd256();
    v.health  = tmp[127:0];
    v.share0  = rnd256();
    v.share1  = rnd256();
    v.stage   = keymgr_stage_e'($urandom_range(0, 3));
    v.max_ver = $urandom();
    v.version = v.max_ver;
    v.other_max = 32'h0;
    v.exp_fv  = 6'h3F;
    v.exp_kv  = 1'b1;
    v.exp_all = 1'b1;
    v.exp_lat = 45;
  endtask

  // Reference: whole-field compare, then early-abort truncation if enabled.
  task automatic model(input vec_t vi, output vec_t vo);
    logic [5:0] ok;
    int words[6];
    int cum;
    words = '{8, 8, 8, 4, 8, 8};
    vo = vi;
    ok[0] = fld_ok(vi.creator, 256);
    ok[1] = fld_ok(vi.owner, 256);
    ok[2] = fld_ok(vi.devid, 256);
    ok[3] = fld_ok({128'h0, vi.health}, 128);
    ok[4] = fld_ok(vi.share0, 256);
    ok[5] = fld_ok(vi.share1, 256);
    vo.exp_kv  = (vi.version <= vi.max_ver);
    vo.exp_fv  = ok;
    vo.exp_lat = 45;
    if (EA) begin
      cum = 0;
      for (int k = 0; k < 5; k++) begin
        cum += words[k];
        if (!ok[k]) begin
          vo.exp_fv  = ok & 6'((7'd1 << (k + 1)) - 7'd1);
          vo.exp_lat = cum + 2;
          break;
        end
      end
    end
    vo.exp_all = (&vo.exp_fv) & vo.exp_kv;
  endtask

  task automatic apply(input vec_t v);
    bus.creator_seed_i = v.creator;
    bus.owner_seed_i   = v.owner;
    bus.devid_i        = v.devid;
    bus.health_state_i = v.health;
    bus.key_i.key[0]   = v.share0;
    bus.key_i.key[1]   = v.share1;
    bus.key_i.valid    = 1'($urandom_range(0, 1));
    bus.stage_sel_i    = v.stage;
    bus.key_version_i  = v.version;
    for (int s = 0; s < NumStages; s++)
      bus.max_key_versions_i[s] = (s == int'(v.stage)) ? v.max_ver : v.other_max;
  endtask

  // Drive one scan and compare against the scoreboard entry when done_o rises.
  task automatic run_vec(input int id, input vec_t v);
    exp_t e;
    int edges;
    apply(v);
    e.id  = id;
    e.fv  = v.exp_fv;
    e.kv  = v.exp_kv;
    e.all = v.exp_all;
    e.lat = v.exp_lat;
    sb.push_back(e);
    bus.start_i = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check($sformatf("v%0d_busy_after_accept", id), bus.busy_o, 1);
    check($sformatf("v%0d_kv_at_accept", id), bus.key_version_vld_o, v.exp_kv);
    while (!bus.done_o && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!bus.done_o) begin
      check($sformatf("v%0d_done_timeout", e.id), bus.done_o, 1);
    end else begin
      check($sformatf("v%0d_latency", e.id), edges, e.lat);
      check($sformatf("v%0d_field_vld", e.id), bus.field_vld_o, e.fv);
      check($sformatf("v%0d_kv_vld", e.id), bus.key_version_vld_o, e.kv);
      check($sformatf("v%0d_all_vld", e.id), bus.all_vld_o, e.all);
      check($sformatf("v%0d_busy_at_done", e.id), bus.busy_o, 0);
      $display("vec %0d: latency=%0d field_vld=%02h kv_vld=%0b all_vld=%0b",
               e.id, edges, bus.field_vld_o, bus.key_version_vld_o, bus.all_vld_o);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", e.id), bus.done_o, 0);
      check($sformatf("v%0d_field_vld_hold", e.id), bus.field_vld_o, e.fv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int edges, ndone, first_done, second_done;

    bus.start_i = 1'b0;
    new_vec(v);
    apply(v);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_field_vld", bus.field_vld_o, 0);
    check("rst_kv_vld", bus.key_version_vld_o, 0);
    check("rst_all_vld", bus.all_vld_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- vector table ----------------
    for (int i = 0; i < NumVecs; i++) new_vec(vecs[i]);
    // 0: random, version == max
    vecs[0].stage = StageOwnerKey;
    // 1: creator all-0, health all-1
    vecs[1].creator = '0;
    vecs[1].health  = '1;
    vecs[1].exp_fv  = EA ? 6'h00 : 6'h36;
    vecs[1].exp_all = 1'b0;
    vecs[1].exp_lat = EA ? 10 : 45;
    // 2: devid all-1 except bit 255, share1 all-0 except bit 0
    vecs[2].devid = '1;
    vecs[2].devid[255] = 1'b0;
    vecs[2].share1 = 256'd1;
    // 3..5: version compare against max=5 on different stages
    vecs[3].stage = StageCreatorRootKey; vecs[3].max_ver = 32'd5; vecs[3].version = 32'd5;
    vecs[3].other_max = 32'd0;
    vecs[4].stage = StageOwnerIntKey; vecs[4].max_ver = 32'd5; vecs[4].version = 32'd6;
    vecs[4].other_max = 32'hFFFF_FFFF; vecs[4].exp_kv = 1'b0; vecs[4].exp_all = 1'b0;
    vecs[5].stage = StageDisable; vecs[5].max_ver = 32'd5; vecs[5].version = 32'd0;
    vecs[5].other_max = 32'd0;
    // 6: owner seed all-0
    vecs[6].owner   = '0;
    vecs[6].exp_fv  = EA ? 6'h01 : 6'h3D;
    vecs[6].exp_all = 1'b0;
    vecs[6].exp_lat = EA ? 18 : 45;
    // 7: share1 all-1 (last field invalid)
    vecs[7].share1  = '1;
    vecs[7].exp_fv  = 6'h1F;
    vecs[7].exp_all = 1'b0;
    // 8: single set bit in creator, single cleared bit in health
    vecs[8].creator = 256'd1 << 100;
    vecs[8].health  = '1;
    vecs[8].health[64] = 1'b0;
    // 9: unsigned compare, version top bit set
    vecs[9].max_ver = 32'h7FFF_FFFF; vecs[9].version = 32'h8000_0000;
    vecs[9].other_max = 32'hFFFF_FFFF; vecs[9].exp_kv = 1'b0; vecs[9].exp_all = 1'b0;
    // 10..12: random version against random max, expectations from the model
    for (int i = 10; i < NumVecs; i++) begin
      vecs[i].max_ver   = $urandom();
      vecs[i].version   = $urandom();
      vecs[i].other_max = ~vecs[i].max_ver;
      model(vecs[i], vecs[i]);
    end

    for (int i = 0; i < NumVecs; i++) run_vec(i, vecs[i]);

    // ---------------- reset in the middle of a scan ----------------
    new_vec(v);
    apply(v);
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_field_vld", bus.field_vld_o, 0);
    check("midrst_kv_vld", bus.key_version_vld_o, 0);
    check("midrst_all_vld", bus.all_vld_o, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("mid-scan reset: outputs cleared, restarting scan");
    run_vec(100, v);

    // ---------------- start held high across DONE ----------------
    new_vec(v);
    apply(v);
    bus.start_i = 1'b1;
    edges = 0;
    ndone = 0;
    first_done = 0;
    second_done = 0;
    while (ndone < 2 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done_o) begin
        ndone++;
        if (ndone == 1) first_done = edges;
        else second_done = edges;
      end
    end
    bus.start_i = 1'b0;
    check("held_done_count", ndone, 2);
    check("held_first_latency", first_done, 45);
    check("held_restart_gap", second_done - first_done, 46);
    repeat (2) @(negedge clk);
    check("held_no_extra_accept", bus.busy_o, 0);
    $display("held start: done at %0d and %0d", first_done, second_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
